// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, FSM states and the control-output bundle for the pipeline sequencer.
// Pure definitions: no latency, no backpressure.
package pipe_ctrl_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_LOAD  = 5'd3;
  localparam logic [4:0] OP_STORE = 5'd7;
  localparam int         REG_ZERO = 0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrlState_t;

  typedef struct packed {
    logic pcEn;
    logic enIfid;
    logic enIdex;
    logic enExmem;
    logic enMemwb;
    logic flushIfid;
    logic flushIdex;
    logic memReq;
  } ctrlOut_t;

  // Every stage advances, no bubbles; caller chooses whether memory is being driven.
  function automatic ctrlOut_t ctrlAdvance(input logic memReq);
    ctrlOut_t c;
    c.pcEn      = 1'b1;
    c.enIfid    = 1'b1;
    c.enIdex    = 1'b1;
    c.enExmem   = 1'b1;
    c.enMemwb   = 1'b1;
    c.flushIfid = 1'b0;
    c.flushIdex = 1'b0;
    c.memReq    = memReq;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: decode reads a register the load in ID/EX has not yet produced.
// Combinational, zero latency; no flow control of its own.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 9
) (
  input  logic             idValid,
  input  logic             exIsLoad,
  input  logic [REG_W-1:0] exRd,
  input  logic [REG_W-1:0] idRs1,
  input  logic [REG_W-1:0] idRs2,
  output logic             loadUse
);

  logic rdLive;
  logic rsMatch;

  // Writes to the zero register never create a dependency.
  assign rdLive  = (exRd != REG_W'(REG_ZERO));
  assign rsMatch = (exRd == idRs1) | (exRd == idRs2);
  assign loadUse = idValid & exIsLoad & rdLive & rsMatch;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy enables/flushes, 0-cycle latency.
// Memory not ready freezes every stage until completion or timeout; load-use inserts one bubble.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int REG_W   = 9,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [OP_W-1:0]  ex_opcode,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic [OP_W-1:0]  mem_opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  ctrlState_t        state;
  ctrlState_t        stateNext;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitCntNext;
  logic              memErrSet;
  logic              isMem;
  logic              exIsLoad;
  logic              loadUse;
  logic              waitDone;
  ctrlOut_t          ctl;

  assign isMem    = (mem_opcode == OP_W'(OP_LOAD)) | (mem_opcode == OP_W'(OP_STORE));
  assign exIsLoad = (ex_opcode == OP_W'(OP_LOAD));
  assign waitDone = mem_ready | (waitCnt == WAIT_LAST);

  hazard_detect #(
    .REG_W (REG_W)
  ) uHazard (
    .idValid  (id_valid),
    .exIsLoad (exIsLoad),
    .exRd     (ex_rd),
    .idRs1    (id_rs1),
    .idRs2    (id_rs2),
    .loadUse  (loadUse)
  );

  always_comb begin
    ctl         = '0;
    stateNext   = state;
    waitCntNext = waitCnt;
    memErrSet   = 1'b0;

    // Reset gates the Mealy outputs directly so an aborted access drops mem_req at once.
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (isMem && !mem_ready) begin
            ctl.memReq  = 1'b1;
            stateNext   = MEM_WAIT;
            waitCntNext = WAIT_W'(1);
          end else begin
            ctl = ctrlAdvance(isMem);
            if (ex_branch_taken) begin
              ctl.flushIfid = 1'b1;
              ctl.flushIdex = 1'b1;
            end else if (loadUse) begin
              ctl.pcEn      = 1'b0;
              ctl.enIfid    = 1'b0;
              ctl.flushIdex = 1'b1;
            end
          end
        end

        MEM_WAIT: begin
          ctl.memReq = 1'b1;
          if (waitDone) begin
            // Load-use is deliberately not checked here; RUN re-evaluates it next cycle.
            ctl = ctrlAdvance(1'b1);
            if (ex_branch_taken) begin
              ctl.flushIfid = 1'b1;
              ctl.flushIdex = 1'b1;
            end
            memErrSet   = ~mem_ready;
            stateNext   = RUN;
            waitCntNext = '0;
          end else begin
            waitCntNext = waitCnt + WAIT_W'(1);
          end
        end

        default: begin
          stateNext   = RUN;
          waitCntNext = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      waitCnt   <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (memErrSet) begin
        mem_err <= 1'b1;
      end
      if (!ctl.pcEn && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_en      = ctl.pcEn;
  assign en_ifid    = ctl.enIfid;
  assign en_idex    = ctl.enIdex;
  assign en_exmem   = ctl.enExmem;
  assign en_memwb   = ctl.enMemwb;
  assign flush_ifid = ctl.flushIfid;
  assign flush_idex = ctl.flushIdex;
  assign mem_req    = ctl.memReq;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short timeout and a narrow stall counter.
// Inputs change 1 time unit after posedge; outputs are sampled on the falling edge.
module tb_pipeline_ctrl;

  localparam int OP_W    = 5;
  localparam int REG_W   = 9;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // Bit order: pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, mem_req
  localparam logic [7:0] C_ZERO   = 8'b0000_0000;
  localparam logic [7:0] C_RUN    = 8'b1111_1000;
  localparam logic [7:0] C_LU     = 8'b0011_1010;
  localparam logic [7:0] C_BR     = 8'b1111_1110;
  localparam logic [7:0] C_WAIT   = 8'b0000_0001;
  localparam logic [7:0] C_DONE   = 8'b1111_1001;
  localparam logic [7:0] C_DONEBR = 8'b1111_1111;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [OP_W-1:0]  ex_opcode;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic [OP_W-1:0]  mem_opcode;
  logic             mem_ready;
  logic             mem_req;
  logic             pc_en;
  logic             en_ifid;
  logic             en_idex;
  logic             en_exmem;
  logic             en_memwb;
  logic             flush_ifid;
  logic             flush_idex;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [7:0]       ctl;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, mem_req};

  pipeline_ctrl #(
    .OP_W    (OP_W),
    .REG_W   (REG_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_opcode       (ex_opcode),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_opcode      (mem_opcode),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .pc_en           (pc_en),
    .en_ifid         (en_ifid),
    .en_idex         (en_idex),
    .en_exmem        (en_exmem),
    .en_memwb        (en_memwb),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .mem_err         (mem_err),
    .stall_cnt       (stall_cnt)
  );

  task automatic setIdle();
    id_valid        = 1'b0;
    id_rs1          = '0;
    id_rs2          = '0;
    ex_opcode       = 5'd11;
    ex_rd           = '0;
    ex_branch_taken = 1'b0;
    mem_opcode      = 5'd11;
    mem_ready       = 1'b0;
  endtask

  task automatic setLoadUse();
    id_valid  = 1'b1;
    ex_opcode = 5'd3;
    ex_rd     = 9'd8;
    id_rs1    = 9'd5;
    id_rs2    = 9'd8;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setIdle();
    @(negedge clk);
    totalCnt++; if (ctl !== C_ZERO) $display("FAIL rst_ctl got=%b exp=%b", ctl, C_ZERO); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd0) $display("FAIL rst_stall got=%0d exp=0", stall_cnt); else passCnt++;
    totalCnt++; if (mem_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", mem_err); else passCnt++;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL rel_ctl got=%b exp=%b", ctl, C_RUN); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd0) $display("FAIL rel_stall got=%0d exp=0", stall_cnt); else passCnt++;
  endtask

  task automatic test_load_use();
    nextCycle();
    setLoadUse();
    @(negedge clk);
    totalCnt++; if (ctl !== C_LU) $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU); else passCnt++;
    nextCycle();
    setIdle();
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL lu_after got=%b exp=%b", ctl, C_RUN); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd1) $display("FAIL lu_stall1 got=%0d exp=1", stall_cnt); else passCnt++;
    // Destination is the zero register: never a hazard.
    nextCycle();
    setLoadUse();
    ex_rd  = '0;
    id_rs1 = '0;
    id_rs2 = '0;
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL lu_rd0 got=%b exp=%b", ctl, C_RUN); else passCnt++;
    nextCycle();
    setLoadUse();
    id_valid = 1'b0;
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL lu_invalid got=%b exp=%b", ctl, C_RUN); else passCnt++;
    nextCycle();
    setLoadUse();
    ex_opcode = 5'd7;
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL lu_store got=%b exp=%b", ctl, C_RUN); else passCnt++;
    nextCycle();
    setLoadUse();
    id_rs1 = 9'd8;
    id_rs2 = 9'd2;
    @(negedge clk);
    totalCnt++; if (ctl !== C_LU) $display("FAIL lu_rs1 got=%b exp=%b", ctl, C_LU); else passCnt++;
    nextCycle();
    setIdle();
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL lu_after2 got=%b exp=%b", ctl, C_RUN); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd2) $display("FAIL lu_stall2 got=%0d exp=2", stall_cnt); else passCnt++;
  endtask

  task automatic test_branch();
    nextCycle();
    setLoadUse();
    ex_branch_taken = 1'b1;
    @(negedge clk);
    totalCnt++; if (ctl !== C_BR) $display("FAIL br_lu got=%b exp=%b", ctl, C_BR); else passCnt++;
    nextCycle();
    setIdle();
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL br_after got=%b exp=%b", ctl, C_RUN); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd2) $display("FAIL br_stall got=%0d exp=2", stall_cnt); else passCnt++;
  endtask

  task automatic test_mem_wait();
    nextCycle();
    mem_opcode = 5'd7;
    mem_ready  = 1'b0;
    @(negedge clk);
    totalCnt++; if (ctl !== C_WAIT) $display("FAIL mw_first got=%b exp=%b", ctl, C_WAIT); else passCnt++;
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      @(negedge clk);
      totalCnt++; if (ctl !== C_WAIT) $display("FAIL mw_hold%0d got=%b exp=%b", i, ctl, C_WAIT); else passCnt++;
    end
    // Completion with a live load-use pattern: it must not stall this cycle.
    nextCycle();
    mem_ready = 1'b1;
    setLoadUse();
    id_rs1 = 9'd8;
    @(negedge clk);
    totalCnt++; if (ctl !== C_DONE) $display("FAIL mw_done got=%b exp=%b", ctl, C_DONE); else passCnt++;
    nextCycle();
    setIdle();
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL mw_run got=%b exp=%b", ctl, C_RUN); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd5) $display("FAIL mw_stall got=%0d exp=5", stall_cnt); else passCnt++;
    totalCnt++; if (mem_err !== 1'b0) $display("FAIL mw_err got=%b exp=0", mem_err); else passCnt++;
    nextCycle();
    mem_opcode = 5'd3;
    mem_ready  = 1'b1;
    @(negedge clk);
    totalCnt++; if (ctl !== C_DONE) $display("FAIL mw_zero got=%b exp=%b", ctl, C_DONE); else passCnt++;
    nextCycle();
    setIdle();
    @(negedge clk);
    totalCnt++; if (stall_cnt !== 4'd5) $display("FAIL mw_zero_stall got=%0d exp=5", stall_cnt); else passCnt++;
  endtask

  task automatic test_timeout();
    nextCycle();
    mem_opcode = 5'd3;
    mem_ready  = 1'b0;
    @(negedge clk);
    totalCnt++; if (ctl !== C_WAIT) $display("FAIL to_first got=%b exp=%b", ctl, C_WAIT); else passCnt++;
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      @(negedge clk);
      totalCnt++; if (ctl !== C_WAIT) $display("FAIL to_hold%0d got=%b exp=%b", i, ctl, C_WAIT); else passCnt++;
      totalCnt++; if (mem_err !== 1'b0) $display("FAIL to_err_early%0d got=%b exp=0", i, mem_err); else passCnt++;
    end
    nextCycle();
    ex_branch_taken = 1'b1;
    @(negedge clk);
    totalCnt++; if (ctl !== C_DONEBR) $display("FAIL to_last got=%b exp=%b", ctl, C_DONEBR); else passCnt++;
    totalCnt++; if (mem_err !== 1'b0) $display("FAIL to_err_pre got=%b exp=0", mem_err); else passCnt++;
    nextCycle();
    setIdle();
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL to_run got=%b exp=%b", ctl, C_RUN); else passCnt++;
    totalCnt++; if (mem_err !== 1'b1) $display("FAIL to_err got=%b exp=1", mem_err); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd8) $display("FAIL to_stall got=%0d exp=8", stall_cnt); else passCnt++;
    nextCycle();
    @(negedge clk);
    totalCnt++; if (mem_err !== 1'b1) $display("FAIL to_sticky got=%b exp=1", mem_err); else passCnt++;
  endtask

  task automatic test_saturation();
    nextCycle();
    setLoadUse();
    repeat (6) @(posedge clk);
    @(negedge clk);
    totalCnt++; if (ctl !== C_LU) $display("FAIL sat_ctl got=%b exp=%b", ctl, C_LU); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd14) $display("FAIL sat_14 got=%0d exp=14", stall_cnt); else passCnt++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    totalCnt++; if (stall_cnt !== 4'd15) $display("FAIL sat_max got=%0d exp=15", stall_cnt); else passCnt++;
    nextCycle();
    setIdle();
    @(negedge clk);
    totalCnt++; if (stall_cnt !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", stall_cnt); else passCnt++;
    totalCnt++; if (mem_err !== 1'b1) $display("FAIL sat_err got=%b exp=1", mem_err); else passCnt++;
  endtask

  task automatic test_async_reset();
    nextCycle();
    mem_opcode = 5'd7;
    mem_ready  = 1'b0;
    nextCycle();
    nextCycle();
    @(negedge clk);
    totalCnt++; if (ctl !== C_WAIT) $display("FAIL ar_wait got=%b exp=%b", ctl, C_WAIT); else passCnt++;
    #2;
    rst = 1'b1;
    #1;
    totalCnt++; if (ctl !== C_ZERO) $display("FAIL ar_ctl got=%b exp=%b", ctl, C_ZERO); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd0) $display("FAIL ar_stall got=%0d exp=0", stall_cnt); else passCnt++;
    totalCnt++; if (mem_err !== 1'b0) $display("FAIL ar_err got=%b exp=0", mem_err); else passCnt++;
    nextCycle();
    rst = 1'b0;
    setIdle();
    @(negedge clk);
    totalCnt++; if (ctl !== C_RUN) $display("FAIL ar_run got=%b exp=%b", ctl, C_RUN); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd0) $display("FAIL ar_stall2 got=%0d exp=0", stall_cnt); else passCnt++;
    nextCycle();
    mem_opcode = 5'd7;
    mem_ready  = 1'b0;
    @(negedge clk);
    totalCnt++; if (ctl !== C_WAIT) $display("FAIL ar_newwait got=%b exp=%b", ctl, C_WAIT); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
